step_sequencer: RTL and testbench
=================================

# step_sequencer

Parametrised pedestrian/step sequencer: an N-bit state register advanced by a request input, with selectable direction, wrap or saturate at a programmable terminal state, synchronous clear and load, and optional rising-edge qualification of the request. It replaces the fixed 3-bit, up-only, level-sensitive sequencer in the signal-controller path. It drives downstream light/phase decode through `state` and the `step`/`done` strobes.

## Interface
- `WIDTH`, 3: state width in bits; must be at least 1.
- `LAST`, 2**WIDTH-1: terminal state; must satisfy 0 < LAST ≤ 2**WIDTH-1.
- `EDGE`, 1: 1 means advance on a rising edge of `ped`; 0 means advance every cycle `ped` is high, matching legacy level behaviour.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ped`  in  1  advance request; synchronous to `clk`.
- `dir`  in  1  0 = count up, 1 = count down.
- `wrap`  in  1  1 = wrap at the end state, 0 = saturate there.
- `clr`  in  1  synchronous clear to 0.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  WIDTH  value to load; values above LAST are clamped to LAST.
- `state`  out  WIDTH  current state, registered.
- `step`  out  1  one-cycle pulse, registered, high in the cycle after any advance that changed `state`.
- `done`  out  1  one-cycle pulse, registered, high in the cycle after an advance from the end state (a wrap, or a saturated hold).
- `tc`  out  1  combinational; high when `state` equals the end state for the current `dir` (LAST going up, 0 going down).

## Operation
- Advance qualifier `adv`:
  - EDGE=1: `adv = ped & ~ped_q`, where `ped_q` is `ped` registered.
  - EDGE=0: `adv = ped`.
- Per-cycle priority (highest first): `clr`, then `load`, then `adv`, then hold.
  - `clr`: state ← 0. No `step` or `done`.
  - `load`: state ← min(`load_val`, LAST). No `step` or `done`.
  - `adv`, up direction:
    - state < LAST: state+1, `step` pulses.
    - state == LAST and wrap=1: state ← 0, `step` and `done` pulse.
    - state == LAST and wrap=0: state holds, `done` pulses, no `step`.
  - `adv`, down direction:
    - state > 0: state−1, `step` pulses.
    - state == 0 and wrap=1: state ← LAST, `step` and `done` pulse.
    - state == 0 and wrap=0: state holds, `done` pulses, no `step`.
- States above LAST are unreachable through any input. With wrap=1 the count is modulo LAST+1, not modulo 2**WIDTH.
- A `clr` or `load` in the same cycle as a `ped` rising edge consumes that edge: `ped_q` still updates, so the edge does not re-fire later.
- `dir` and `wrap` are sampled in the same cycle as `adv`. Changing them mid-sequence is legal and takes effect on the next advance.

## Timing
- Reset (`rst_n` low, asynchronous): `state`=0, `step`=0, `done`=0, `ped_q`=0. `tc` then shows 1 if dir=1, else 0.
- Reset release is synchronous in effect: the first possible advance is on the first rising edge with `rst_n` high.
- Reset asserted mid-sequence forces all registers to their reset values immediately, regardless of `clk`. No pulse survives.
- Latency: `state` updates on the clock edge that samples `adv`. `step` and `done` are high for exactly one cycle, the cycle following that edge.
- EDGE=1 with `ped` held high: exactly one advance. A new advance needs `ped` low for at least one cycle.
- EDGE=0 with `ped` held high: one advance per cycle, at a maximum rate of one per clock.

## Structure
- Shared package `step_seq_pkg`:
  - constants `DIR_UP`=1'b0 and `DIR_DOWN`=1'b1;
  - function `clamp_last(val, last)`, reused by the load path and the bench.
- Sub-module `edge_detect`: rising-edge detector with parameter `EN`; EN=0 passes the input through. Instantiated once for `ped`.
- The top level holds the state register, the next-state logic, and the pulse registers.

## Test plan
1. WIDTH=3, LAST=7, EDGE=0, dir=0, wrap=1; `ped` held high 9 cycles from reset → `state` 1,2,…,7,0,1; `done` pulses once, in the cycle after 7→0; `step` pulses 9 times.
2. EDGE=1; `ped` high for 5 cycles, low 1 cycle, high 1 cycle → `state` 0→1→2 only; 2 `step` pulses.
3. WIDTH=4, LAST=9, dir=0, wrap=0; load 12 → `state`=9 and `tc`=1. Then 3 advances → `state` stays 9, 3 `done` pulses, 0 `step` pulses.
4. LAST=5, dir=1, wrap=1, starting from 0; 2 advances → `state` 5 then 4; `done` pulses once, after 0→5.
5. `clr`, `load` (val=3) and a `ped` rising edge all in the same cycle from state 6 → `state`=0, no pulses, no later advance from that edge. Next cycle `load` with val=3 → `state`=3.
6. `rst_n` pulled low asynchronously between clock edges at state 4 → `state`=0 and `step`/`done`=0 before the next clock edge. First advance after release → `state`=1.

Source files
------------

// File: rtl/step_seq_pkg.sv
// Shared constants and helpers for the step sequencer and its bench.
package step_seq_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic [31:0] clamp_last(input logic [31:0] val, input logic [31:0] last);
    return (val > last) ? last : val;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge qualifier; with EN=0 the input passes straight through.
module edge_detect #(
  parameter int EN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // The history register always tracks the input, so an edge swallowed by a
  // higher-priority action upstream never re-fires later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_i;
  end

  assign rise_o = (EN != 0) ? (d_i & ~d_q) : d_i;

endmodule

// File: rtl/step_sequencer.sv
// Up/down step sequencer with wrap or saturate at LAST, clear/load, and
// registered step/done strobes.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int LAST  = 2**WIDTH-1,
  parameter int EDGE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ped,
  input  logic             dir,
  input  logic             wrap,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic             step,
  output logic             done,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

  logic             adv;
  logic             at_end;
  logic [WIDTH-1:0] state_q, state_d;
  logic             step_q, step_d;
  logic             done_q, done_d;

  edge_detect #(.EN(EDGE)) u_ped_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ped),
    .rise_o(adv)
  );

  assign at_end = (dir == DIR_DOWN) ? (state_q == '0) : (state_q == LAST_V);

  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    if (clr) begin
      state_d = '0;
    end else if (load) begin
      state_d = WIDTH'(clamp_last(32'(load_val), 32'(LAST)));
    end else if (adv) begin
      if (at_end) begin
        done_d = 1'b1;
        if (wrap) begin
          step_d  = 1'b1;
          state_d = (dir == DIR_DOWN) ? LAST_V : '0;
        end
      end else begin
        step_d  = 1'b1;
        state_d = (dir == DIR_DOWN) ? (state_q - 1'b1) : (state_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign state = state_q;
  assign step  = step_q;
  assign done  = done_q;
  assign tc    = at_end;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer across four parameter sets.
module tb_step_sequencer;
  import step_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // A: WIDTH3 LAST7 level; B: WIDTH3 LAST7 edge; C: WIDTH4 LAST9 edge; D: WIDTH3 LAST5 edge
  logic       a_ped = 0, a_dir = 0, a_wrap = 0, a_clr = 0, a_load = 0;
  logic [2:0] a_lv = '0, a_state;
  logic       a_step, a_done, a_tc;
  logic       b_ped = 0, b_dir = 0, b_wrap = 0, b_clr = 0, b_load = 0;
  logic [2:0] b_lv = '0, b_state;
  logic       b_step, b_done, b_tc;
  logic       c_ped = 0, c_dir = 0, c_wrap = 0, c_clr = 0, c_load = 0;
  logic [3:0] c_lv = '0, c_state;
  logic       c_step, c_done, c_tc;
  logic       d_ped = 0, d_dir = 1, d_wrap = 1, d_clr = 0, d_load = 0;
  logic [2:0] d_lv = '0, d_state;
  logic       d_step, d_done, d_tc;

  step_sequencer #(.WIDTH(3), .LAST(7), .EDGE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .ped(a_ped), .dir(a_dir), .wrap(a_wrap), .clr(a_clr),
    .load(a_load), .load_val(a_lv), .state(a_state), .step(a_step), .done(a_done), .tc(a_tc));
  step_sequencer #(.WIDTH(3), .LAST(7), .EDGE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .ped(b_ped), .dir(b_dir), .wrap(b_wrap), .clr(b_clr),
    .load(b_load), .load_val(b_lv), .state(b_state), .step(b_step), .done(b_done), .tc(b_tc));
  step_sequencer #(.WIDTH(4), .LAST(9), .EDGE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .ped(c_ped), .dir(c_dir), .wrap(c_wrap), .clr(c_clr),
    .load(c_load), .load_val(c_lv), .state(c_state), .step(c_step), .done(c_done), .tc(c_tc));
  step_sequencer #(.WIDTH(3), .LAST(5), .EDGE(1)) u_d (
    .clk(clk), .rst_n(rst_n), .ped(d_ped), .dir(d_dir), .wrap(d_wrap), .clr(d_clr),
    .load(d_load), .load_val(d_lv), .state(d_state), .step(d_step), .done(d_done), .tc(d_tc));

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int steps, dones;

  initial begin
    // Reset values
    repeat (2) tick();
    chk("rst_a_state", a_state, 0);
    chk("rst_a_step", a_step, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_tc", a_tc, 0);
    chk("rst_d_tc", d_tc, 1);
    rst_n = 1'b1;

    // 1: level mode, wrap, ped high 9 cycles
    a_wrap = 1; a_ped = 1;
    steps = 0; dones = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("t1_state_%0d", i), a_state, i % 8);
      chk($sformatf("t1_done_%0d", i), a_done, (i == 8) ? 1 : 0);
      steps += a_step; dones += a_done;
    end
    a_ped = 0;
    tick();
    steps += a_step; dones += a_done;
    chk("t1_steps", steps, 9);
    chk("t1_dones", dones, 1);

    // 2: edge mode, high 5, low 1, high 1
    steps = 0;
    b_ped = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      steps += b_step;
      chk($sformatf("t2_state_hold_%0d", i), b_state, 1);
    end
    b_ped = 0; tick(); steps += b_step;
    b_ped = 1; tick(); steps += b_step;
    chk("t2_state_second", b_state, 2);
    b_ped = 0; tick(); steps += b_step;
    tick(); steps += b_step;
    chk("t2_state_final", b_state, 2);
    chk("t2_steps", steps, 2);

    // 3: load clamps above LAST, then saturate
    c_load = 1; c_lv = 4'd12;
    tick();
    c_load = 0;
    chk("t3_load_state", c_state, clamp_last(12, 9));
    chk("t3_load_tc", c_tc, 1);
    chk("t3_load_step", c_step, 0);
    steps = 0; dones = 0;
    for (int i = 0; i < 3; i++) begin
      c_ped = 1; tick(); steps += c_step; dones += c_done;
      chk($sformatf("t3_sat_state_%0d", i), c_state, 9);
      c_ped = 0; tick(); steps += c_step; dones += c_done;
    end
    chk("t3_dones", dones, 3);
    chk("t3_steps", steps, 0);

    // 4: down with wrap at LAST=5
    d_ped = 1; tick();
    chk("t4_state_wrap", d_state, 5);
    chk("t4_done_wrap", d_done, 1);
    chk("t4_step_wrap", d_step, 1);
    d_ped = 0; tick();
    d_ped = 1; tick();
    chk("t4_state_dec", d_state, 4);
    chk("t4_done_dec", d_done, 0);
    chk("t4_step_dec", d_step, 1);
    d_ped = 0;

    // 5: clr + load + ped edge together from state 6
    b_load = 1; b_lv = 3'd6; tick();
    b_load = 0;
    chk("t5_pre_state", b_state, 6);
    b_clr = 1; b_load = 1; b_lv = 3'd3; b_ped = 1;
    tick();
    b_clr = 0; b_load = 0;
    chk("t5_clr_state", b_state, 0);
    chk("t5_clr_step", b_step, 0);
    chk("t5_clr_done", b_done, 0);
    tick();
    chk("t5_no_refire_state", b_state, 0);
    chk("t5_no_refire_step", b_step, 0);
    b_load = 1; tick();
    b_load = 0; b_ped = 0;
    chk("t5_load3", b_state, 3);

    // 6: async reset mid-cycle while a step pulse is live
    tick();
    b_ped = 1; tick();
    b_ped = 0;
    chk("t6_pre_state", b_state, 4);
    chk("t6_pre_step", b_step, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_state", b_state, 0);
    chk("t6_rst_step", b_step, 0);
    chk("t6_rst_done", b_done, 0);
    #1 rst_n = 1'b1;
    b_ped = 1; tick();
    b_ped = 0;
    chk("t6_first_adv", b_state, 1);
    chk("t6_first_step", b_step, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
